// File: rtl/element_attribute_collector_if.sv
// rtl/element_attribute_collector_if.sv - attribute/tag inputs and element record outputs of the collector
interface element_attribute_collector_if #(
  parameter int TYPE_W  = 4,
  parameter int VAL_W   = 24,
  parameter int NUM_ATT = 11
);
  logic                     tag_open;
  logic                     tag_close;
  logic                     attr_finished;
  logic [TYPE_W-1:0]        attr_type;
  logic [VAL_W-1:0]         attr_value;
  logic                     stall;
  logic                     out_valid;
  logic                     out_ready;
  logic [NUM_ATT-1:0]       out_present;
  logic [NUM_ATT*VAL_W-1:0] out_values;
  logic                     dup_error;

  modport master (
    output tag_open, tag_close, attr_finished, attr_type, attr_value, out_ready,
    input  stall, out_valid, out_present, out_values, dup_error
  );

  modport slave (
    input  tag_open, tag_close, attr_finished, attr_type, attr_value, out_ready,
    output stall, out_valid, out_present, out_values, dup_error
  );
endinterface

// File: rtl/element_attribute_collector.sv
// rtl/element_attribute_collector.sv - per-element attribute register set with record emit; option macro ATTR_DUP_ERR_EN
module element_attribute_collector #(
  parameter int               TYPE_W  = 4,
  parameter int               VAL_W   = 24,
  parameter int               NUM_ATT = 11,
  parameter logic [VAL_W-1:0] DEF_VAL = '0
) (
  input logic                       clock,
  input logic                       resetn,
  element_attribute_collector_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

  localparam logic [NUM_ATT*VAL_W-1:0] DEF_ALL = {NUM_ATT{DEF_VAL}};

  state_t                   state_q, state_n;
  logic                     pending_q, pending_n;
  logic                     fin_q;
  logic [NUM_ATT-1:0]       work_pres_q, work_pres_n;
  logic [NUM_ATT*VAL_W-1:0] work_val_q, work_val_n;
  logic [NUM_ATT-1:0]       out_pres_q;
  logic [NUM_ATT*VAL_W-1:0] out_val_q;
  logic                     load_out;
  logic                     cap_edge;
  logic                     type_ok;
`ifdef ATTR_DUP_ERR_EN
  logic                     dup_hit;
  logic                     dup_q;
`endif

  // One capture per parser completion: only the 0->1 transition of attr_finished counts.
  assign cap_edge = bus.attr_finished & ~fin_q;
  assign type_ok  = (bus.attr_type != '0) && (bus.attr_type <= TYPE_W'(NUM_ATT));

  // Next-state, working-set update and record load decision.
  always_comb begin
    state_n     = state_q;
    pending_n   = pending_q;
    work_pres_n = work_pres_q;
    work_val_n  = work_val_q;
    load_out    = 1'b0;
`ifdef ATTR_DUP_ERR_EN
    dup_hit     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.tag_open) begin
          state_n     = COLLECT;
          work_pres_n = '0;
          work_val_n  = DEF_ALL;
        end
      end
      COLLECT: begin
        // A new open abandons the current element; a same-cycle capture lands in the new one.
        if (bus.tag_open && !bus.tag_close) begin
          work_pres_n = '0;
          work_val_n  = DEF_ALL;
        end
        if (cap_edge && type_ok) begin
          for (int k = 0; k < NUM_ATT; k++) begin
            if (bus.attr_type == TYPE_W'(k + 1)) begin
`ifdef ATTR_DUP_ERR_EN
              if (work_pres_n[k]) begin
                dup_hit = 1'b1;
              end else begin
                work_pres_n[k]               = 1'b1;
                work_val_n[k*VAL_W +: VAL_W] = bus.attr_value;
              end
`else
              work_pres_n[k]               = 1'b1;
              work_val_n[k*VAL_W +: VAL_W] = bus.attr_value;
`endif
            end
          end
        end
        // Close snapshots the working set including any capture in this same cycle.
        if (bus.tag_close) begin
          state_n   = EMIT;
          load_out  = 1'b1;
          pending_n = bus.tag_open;
        end
      end
      EMIT: begin
        if (bus.tag_open) pending_n = 1'b1;
        if (bus.out_ready) begin
          if (pending_n) begin
            state_n     = COLLECT;
            pending_n   = 1'b0;
            work_pres_n = '0;
            work_val_n  = DEF_ALL;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, pending open, edge history, working set and held output record.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      fin_q       <= 1'b0;
      work_pres_q <= '0;
      work_val_q  <= DEF_ALL;
      out_pres_q  <= '0;
      out_val_q   <= DEF_ALL;
    end else begin
      state_q     <= state_n;
      pending_q   <= pending_n;
      fin_q       <= bus.attr_finished;
      work_pres_q <= work_pres_n;
      work_val_q  <= work_val_n;
      if (load_out) begin
        out_pres_q <= work_pres_n;
        out_val_q  <= work_val_n;
      end
    end
  end

`ifdef ATTR_DUP_ERR_EN
  // Sticky duplicate flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (!resetn) dup_q <= 1'b0;
    else if (dup_hit) dup_q <= 1'b1;
  end
  assign bus.dup_error = dup_q;
`else
  assign bus.dup_error = 1'b0;
`endif

  assign bus.out_valid   = (state_q == EMIT);
  assign bus.stall       = (state_q == EMIT) | pending_q;
  assign bus.out_present = out_pres_q;
  assign bus.out_values  = out_val_q;

endmodule

// File: tb/tb_element_attribute_collector.sv
// tb/tb_element_attribute_collector.sv - directed and random checks of the collector against an element model
module tb_element_attribute_collector;

  localparam int NA = 11;
  localparam int VW = 24;

  logic clock;
  logic resetn;

  element_attribute_collector_if #(.TYPE_W(4), .VAL_W(VW), .NUM_ATT(NA)) ifc ();

  element_attribute_collector #(.TYPE_W(4), .VAL_W(VW), .NUM_ATT(NA), .DEF_VAL('0)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (ifc.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  bit          d_open, d_close, d_fin, d_ready, d_rstn;
  logic [3:0]  d_type;
  logic [23:0] d_val;

  // Reference: the element being built, the record on offer, and an open awaiting acceptance.
  bit          in_element, record_offered, open_waiting, fin_prev, dup_seen;
  bit          cur_pres [NA];
  logic [23:0] cur_val  [NA];
  bit          rec_pres [NA];
  logic [23:0] rec_val  [NA];

  task automatic check_eq(input string tag, input logic [263:0] got, input logic [263:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_element();
    foreach (cur_pres[k]) begin
      cur_pres[k] = 0;
      cur_val[k]  = '0;
    end
  endtask

  task automatic model_cycle();
    bit rise;
    int slot;
    rise     = d_fin && !fin_prev;
    fin_prev = d_fin;
    if (!d_rstn) begin
      in_element = 0; record_offered = 0; open_waiting = 0; fin_prev = 0; dup_seen = 0;
      start_element();
      foreach (rec_pres[k]) begin
        rec_pres[k] = 0;
        rec_val[k]  = '0;
      end
    end else if (record_offered) begin
      if (d_open) open_waiting = 1;
      if (d_ready) begin
        record_offered = 0;
        if (open_waiting) begin
          open_waiting = 0;
          in_element   = 1;
          start_element();
        end
      end
    end else if (in_element) begin
      if (d_open) start_element();
      if (rise && d_type >= 1 && d_type <= NA) begin
        slot = int'(d_type) - 1;
`ifdef ATTR_DUP_ERR_EN
        if (cur_pres[slot]) dup_seen = 1;
        else begin
          cur_pres[slot] = 1;
          cur_val[slot]  = d_val;
        end
`else
        cur_pres[slot] = 1;
        cur_val[slot]  = d_val;
`endif
      end
      if (d_close) begin
        rec_pres       = cur_pres;
        rec_val        = cur_val;
        record_offered = 1;
        in_element     = 0;
      end
    end else if (d_open) begin
      in_element = 1;
      start_element();
    end
  endtask

  task automatic compare_all();
    logic [10:0]  ep;
    logic [263:0] ev;
    foreach (rec_pres[k]) begin
      ep[k]          = rec_pres[k];
      ev[k*VW +: VW] = rec_val[k];
    end
    check_eq("out_valid", ifc.out_valid, record_offered);
    check_eq("stall", ifc.stall, record_offered || open_waiting);
    check_eq("out_present", ifc.out_present, ep);
    check_eq("out_values", ifc.out_values, ev);
    check_eq("dup_error", ifc.dup_error, dup_seen);
  endtask

  task automatic tick();
    ifc.tag_open      = d_open;
    ifc.tag_close     = d_close;
    ifc.attr_finished = d_fin;
    ifc.attr_type     = d_type;
    ifc.attr_value    = d_val;
    ifc.out_ready     = d_ready;
    resetn            = d_rstn;
    @(posedge clock);
    model_cycle();
    #1;
    compare_all();
    d_open  = 0;
    d_close = 0;
  endtask

  task automatic capture(input logic [3:0] t, input logic [23:0] v);
    d_fin = 1; d_type = t; d_val = v;
    tick();
    d_fin = 0;
    tick();
  endtask

  logic [263:0] ev;

  initial begin
    d_open = 0; d_close = 0; d_fin = 0; d_ready = 0; d_type = '0; d_val = '0; d_rstn = 0;
    tick();
    tick();
    check_eq("reset_present", ifc.out_present, '0);
    check_eq("reset_values", ifc.out_values, '0);
    d_rstn = 1;

    // width=640, height=480
    d_open = 1; tick();
    capture(4'd3, 24'd640);
    capture(4'd4, 24'd480);
    d_close = 1; tick();
    ev = '0; ev[2*VW +: VW] = 24'd640; ev[3*VW +: VW] = 24'd480;
    check_eq("s1_valid", ifc.out_valid, 1'b1);
    check_eq("s1_present", ifc.out_present, 11'h00C);
    check_eq("s1_values", ifc.out_values, ev);
    d_ready = 1; tick();
    check_eq("s1_accepted", ifc.out_valid, 1'b0);

    // long has_finished, then out-of-range types
    d_ready = 0;
    d_open = 1; tick();
    d_fin = 1; d_type = 4'd1; d_val = 24'hFF0000;
    repeat (5) tick();
    d_fin = 0; tick();
    capture(4'd0, 24'h123456);
    capture(4'd12, 24'h654321);
    d_close = 1; tick();
    ev = '0; ev[0 +: VW] = 24'hFF0000;
    check_eq("s2_present", ifc.out_present, 11'h001);
    check_eq("s2_values", ifc.out_values, ev);
    d_ready = 1; tick();

    // back-pressure with an open arriving during EMIT
    d_ready = 0;
    d_open = 1; tick();
    capture(4'd2, 24'd7);
    d_close = 1; tick();
    tick();
    d_open = 1; tick();
    tick();
    check_eq("s3_stall", ifc.stall, 1'b1);
    check_eq("s3_held", ifc.out_present, 11'h002);
    d_ready = 1; tick();
    check_eq("s3_released", ifc.out_valid, 1'b0);
    d_ready = 0;
    capture(4'd5, 24'd9);
    d_close = 1; tick();
    check_eq("s3_next_present", ifc.out_present, 11'h010);
    d_ready = 1; tick();

    // two writes to the same slot
    d_ready = 0;
    d_open = 1; tick();
    capture(4'd1, 24'd5);
    capture(4'd1, 24'd9);
    d_close = 1; tick();
`ifdef ATTR_DUP_ERR_EN
    check_eq("s4_slot0", ifc.out_values[23:0], 24'd5);
    check_eq("s4_dup", ifc.dup_error, 1'b1);
`else
    check_eq("s4_slot0", ifc.out_values[23:0], 24'd9);
    check_eq("s4_dup", ifc.dup_error, 1'b0);
`endif
    d_ready = 1; tick();
    d_open = 1; tick();
    d_close = 1; tick();
    tick();

    // close coinciding with a capture edge
    d_ready = 0;
    d_open = 1; tick();
    d_fin = 1; d_type = 4'd2; d_val = 24'd3; d_close = 1; tick();
    d_fin = 0;
    ev = '0; ev[1*VW +: VW] = 24'd3;
    check_eq("s5_present", ifc.out_present, 11'h002);
    check_eq("s5_values", ifc.out_values, ev);
    d_ready = 1; tick();

    // reset mid-element and mid-handshake
    d_open = 1; tick();
    d_rstn = 0; tick();
    d_rstn = 1;
    check_eq("s6_valid", ifc.out_valid, 1'b0);
    check_eq("s6_present", ifc.out_present, '0);
    d_close = 1; tick();
    check_eq("s6_no_record", ifc.out_valid, 1'b0);
    d_ready = 0;
    d_open = 1; tick();
    capture(4'd7, 24'hABCDEF);
    d_close = 1; tick();
    d_rstn = 0; tick();
    d_rstn = 1;
    check_eq("s6_emit_valid", ifc.out_valid, 1'b0);
    check_eq("s6_emit_stall", ifc.stall, 1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      d_open  = ($urandom % 12) == 0;
      d_close = !d_open && (($urandom % 8) == 0);
      d_ready = ($urandom % 2) == 0;
      d_rstn  = ($urandom % 200) != 0;
      if (d_fin) begin
        d_fin = ($urandom % 3) != 0;
      end else if (($urandom % 3) == 0) begin
        d_fin  = 1;
        d_type = 4'($urandom % 16);
        d_val  = 24'($urandom);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
